// File: rtl/ebus_pkg.sv
// Shared EBUS types: function codes, sequencer states and bus width.
package ebus_pkg;

    localparam int EBUS_W = 36;

    typedef enum logic [2:0] {
        CONO  = 3'd0,
        CONI  = 3'd1,
        DATAO = 3'd2,
        DATAI = 3'd3
    } tEBUSFunc;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DEMAND,
        RELEASE,
        RESP
    } tEBUSCtlState;

    // CONI and DATAI read from the device; CONO and DATAO drive the bus.
    function automatic logic isInputFunc(input logic [2:0] func);
        return func[0];
    endfunction

endpackage

// File: rtl/ebus_ctl.sv
// EBUS I/O cycle sequencer: one CONO/CONI/DATAO/DATAI request at a time,
// SETUP -> DEMAND -> RELEASE handshake with per-phase timeout.
module ebus_ctl
    import ebus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DEV_W          = 7
) (
    input  logic              clk,
    input  logic              CROBAR,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [2:0]        reqFunc,
    input  logic [DEV_W-1:0]  reqDev,
    input  logic [EBUS_W-1:0] reqData,
    output logic              rspValid,
    output logic [EBUS_W-1:0] rspData,
    output logic              rspTimeout,
    output logic [DEV_W-1:0]  ebusCS,
    output logic [2:0]        ebusFunc,
    output logic              ebusDemand,
    output logic [EBUS_W-1:0] ebusDataOut,
    output logic              ebusDataOE,
    input  logic              ebusXfer,
    input  logic [EBUS_W-1:0] ebusDataIn
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tEBUSCtlState      state;
    logic [CNT_W-1:0]  cnt;
    logic [EBUS_W-1:0] cap;

    // The registered bus outputs double as the request latches: they are
    // loaded at accept and held unchanged until the cycle ends.
    // NOTE: all sequential state is written with non-blocking assignments so
    // every branch sees the pre-edge values of state, cnt and the bus lines.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state       <= IDLE;
            cnt         <= '0;
            cap         <= '0;
            reqReady    <= 1'b1;
            rspValid    <= 1'b0;
            rspTimeout  <= 1'b0;
            rspData     <= '0;
            ebusCS      <= '0;
            ebusFunc    <= '0;
            ebusDemand  <= 1'b0;
            ebusDataOut <= '0;
            ebusDataOE  <= 1'b0;
        end else begin
            rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        reqReady <= 1'b0;
                        cap      <= '0;
                        if (reqFunc[2]) begin
                            state      <= RESP;
                            rspValid   <= 1'b1;
                            rspTimeout <= 1'b1;
                            rspData    <= '0;
                        end else begin
                            state       <= SETUP;
                            ebusCS      <= reqDev;
                            ebusFunc    <= reqFunc;
                            ebusDataOE  <= !isInputFunc(reqFunc);
                            ebusDataOut <= isInputFunc(reqFunc) ? '0 : reqData;
                        end
                    end
                end
                SETUP: begin
                    state      <= DEMAND;
                    ebusDemand <= 1'b1;
                    cnt        <= '0;
                end
                DEMAND: begin
                    if (ebusXfer) begin
                        if (isInputFunc(ebusFunc)) cap <= ebusDataIn;
                        state      <= RELEASE;
                        ebusDemand <= 1'b0;
                        cnt        <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RESP;
                        rspValid    <= 1'b1;
                        rspTimeout  <= 1'b1;
                        rspData     <= '0;
                        ebusCS      <= '0;
                        ebusFunc    <= '0;
                        ebusDemand  <= 1'b0;
                        ebusDataOut <= '0;
                        ebusDataOE  <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A device still holding xfer at the limit is a timeout,
                    // but whatever it delivered in DEMAND is still returned.
                    if (!ebusXfer || cnt == CNT_LAST) begin
                        state       <= RESP;
                        rspValid    <= 1'b1;
                        rspTimeout  <= ebusXfer;
                        rspData     <= cap;
                        ebusCS      <= '0;
                        ebusFunc    <= '0;
                        ebusDataOut <= '0;
                        ebusDataOE  <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_ctl.sv
// Directed bench for ebus_ctl: a cycle-timeline model derived from the
// handshake rules predicts every output on every cycle of each request.
module tb_ebus_ctl;
    import ebus_pkg::*;

    localparam int T     = 64;
    localparam int DEV_W = 7;
    localparam logic [35:0] JUNK = 36'o525252_525252;

    logic             clk;
    logic             CROBAR;
    logic             reqValid;
    logic             reqReady;
    logic [2:0]       reqFunc;
    logic [DEV_W-1:0] reqDev;
    logic [35:0]      reqData;
    logic             rspValid;
    logic [35:0]      rspData;
    logic             rspTimeout;
    logic [DEV_W-1:0] ebusCS;
    logic [2:0]       ebusFunc;
    logic             ebusDemand;
    logic [35:0]      ebusDataOut;
    logic             ebusDataOE;
    logic             ebusXfer;
    logic [35:0]      ebusDataIn;

    int vectors     = 0;
    int miscompares = 0;

    ebus_ctl #(.TIMEOUT_CYCLES(T), .DEV_W(DEV_W)) dut (
        .clk(clk), .CROBAR(CROBAR),
        .reqValid(reqValid), .reqReady(reqReady), .reqFunc(reqFunc),
        .reqDev(reqDev), .reqData(reqData),
        .rspValid(rspValid), .rspData(rspData), .rspTimeout(rspTimeout),
        .ebusCS(ebusCS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand),
        .ebusDataOut(ebusDataOut), .ebusDataOE(ebusDataOE),
        .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // xfer is high for cycles xs <= k < xe, counted from the accept edge.
    // lat and dem are hand-computed: cycles to rspValid, cycles of demand.
    typedef struct {
        logic [2:0]       func;
        logic [DEV_W-1:0] dev;
        logic [35:0]      data;
        logic [35:0]      din;
        int               xs;
        int               xe;
        int               lat;
        int               dem;
        bit               hold;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int first_in(input int lo, input int hi, input bit want,
                                    input int xs, input int xe);
        for (int k = lo; k <= hi; k++)
            if ((k >= xs && k < xe) == want) return k;
        return -1;
    endfunction

    task automatic drive_bus(input vec_t v, input int k);
        ebusXfer   = (k >= v.xs && k < v.xe);
        ebusDataIn = ebusXfer ? v.din : JUNK;
    endtask

    task automatic present(input vec_t v);
        reqFunc = v.func;
        reqDev  = v.dev;
        reqData = v.data;
    endtask

    // Called just after a negedge in an IDLE cycle; returns just after the
    // negedge of the IDLE cycle that follows the response.
    task automatic run_vec(input int idx, input vec_t v, input vec_t nxt);
        int d, r, resp, obs_lat, dem_cnt;
        bit res, inp, act, dem_exp, to;
        logic [35:0] rdata;
        string tag;
        res = v.func[2];
        inp = v.func[0];
        d = -1;
        to = 1'b1;
        rdata = '0;
        if (res) begin
            resp = 1;
        end else begin
            d = first_in(2, 1 + T, 1'b1, v.xs, v.xe);
            if (d < 0) begin
                resp = 2 + T;
            end else begin
                r = first_in(d + 1, d + T, 1'b0, v.xs, v.xe);
                resp = (r < 0) ? d + 1 + T : r + 1;
                to = (r < 0);
                rdata = inp ? v.din : '0;
            end
        end

        tag = $sformatf("v%0d c0", idx);
        check({tag, " reqReady"}, 64'(reqReady), 64'd1);
        check({tag, " rspValid"}, 64'(rspValid), 64'd0);
        reqValid = 1'b1;
        present(v);
        drive_bus(v, 0);
        obs_lat = -1;
        dem_cnt = 0;
        @(negedge clk);
        for (int k = 1; k <= resp; k++) begin
            tag = $sformatf("v%0d c%0d", idx, k);
            act = !res && k < resp;
            dem_exp = act && k >= 2 && (d < 0 || k <= d);
            check({tag, " reqReady"}, 64'(reqReady), 64'd0);
            check({tag, " rspValid"}, 64'(rspValid), 64'(k == resp));
            check({tag, " ebusDemand"}, 64'(ebusDemand), 64'(dem_exp));
            check({tag, " ebusCS"}, 64'(ebusCS), act ? 64'(v.dev) : 64'd0);
            check({tag, " ebusFunc"}, 64'(ebusFunc), act ? 64'(v.func) : 64'd0);
            check({tag, " ebusDataOE"}, 64'(ebusDataOE), 64'(act && !inp));
            if (!act || !inp)
                check({tag, " ebusDataOut"}, 64'(ebusDataOut), act ? 64'(v.data) : 64'd0);
            if (k == resp) begin
                check({tag, " rspTimeout"}, 64'(rspTimeout), 64'(to));
                check({tag, " rspData"}, 64'(rspData), 64'(rdata));
            end
            if (rspValid && obs_lat < 0) obs_lat = k;
            if (ebusDemand) dem_cnt++;
            reqValid = v.hold;
            if (v.hold) present(nxt);
            drive_bus(v, k);
            @(negedge clk);
        end
        tag = $sformatf("v%0d", idx);
        check({tag, " latency"}, 64'(obs_lat), 64'(v.lat));
        check({tag, " demand_cycles"}, 64'(dem_cnt), 64'(v.dem));
    endtask

    initial begin : stim
        vec_t fresh;
        vecs[0] = '{CONO,  7'o20, 36'o123456_654321, 36'o0,             3, 4,    5,  2,  1'b0};
        vecs[1] = '{DATAI, 7'o04, 36'o0,             36'o777000_000777, 3, 4,    5,  2,  1'b0};
        vecs[2] = '{CONI,  7'o55, 36'o0,             36'o111,           0, 0,    66, 64, 1'b0};
        vecs[3] = '{3'd5,  7'o33, 36'o7,             36'o0,             0, 0,    1,  0,  1'b0};
        vecs[4] = '{DATAI, 7'o12, 36'o0,             36'o252525_252525, 0, 1000, 67, 1,  1'b0};
        vecs[5] = '{DATAO, 7'o77, 36'o1,             36'o0,             2, 3,    4,  1,  1'b1};
        vecs[6] = '{DATAI, 7'o03, 36'o0,             36'o400000_000001, 2, 4,    5,  1,  1'b1};
        vecs[7] = '{CONO,  7'o01, 36'o777777_777777, 36'o0,             4, 5,    6,  3,  1'b1};
        vecs[8] = '{3'd7,  7'o02, 36'o5,             36'o0,             0, 0,    1,  0,  1'b0};
        fresh   = '{CONI,  7'o06, 36'o0,             36'o135,           2, 3,    4,  1,  1'b0};

        CROBAR = 1'b1;
        reqValid = 1'b0;
        reqFunc = '0;
        reqDev = '0;
        reqData = '0;
        ebusXfer = 1'b0;
        ebusDataIn = '0;
        #1;
        check("reset reqReady", 64'(reqReady), 64'd1);
        check("reset rspValid", 64'(rspValid), 64'd0);
        check("reset rspTimeout", 64'(rspTimeout), 64'd0);
        check("reset rspData", 64'(rspData), 64'd0);
        check("reset bus", {ebusDemand, ebusDataOE, 3'(ebusFunc), 7'(ebusCS), 36'(ebusDataOut)}, 64'd0);
        @(negedge clk);
        CROBAR = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_vec(i, vecs[i], vecs[(i + 1) % 9]);

        // Reset in the middle of a DATAO demand phase.
        reqValid = 1'b1;
        reqFunc  = DATAO;
        reqDev   = 7'o40;
        reqData  = 36'o654321;
        ebusXfer = 1'b0;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        check("crobar pre demand", 64'(ebusDemand), 64'd1);
        check("crobar pre oe", 64'(ebusDataOE), 64'd1);
        #2 CROBAR = 1'b1;
        #1;
        check("crobar async bus", {ebusDemand, ebusDataOE, 3'(ebusFunc), 7'(ebusCS), 36'(ebusDataOut)}, 64'd0);
        check("crobar async reqReady", 64'(reqReady), 64'd1);
        check("crobar async rspValid", 64'(rspValid), 64'd0);
        @(negedge clk);
        CROBAR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post crobar %0d rspValid", i), 64'(rspValid), 64'd0);
            check($sformatf("post crobar %0d reqReady", i), 64'(reqReady), 64'd1);
            check($sformatf("post crobar %0d demand", i), 64'(ebusDemand), 64'd0);
        end
        run_vec(9, fresh, fresh);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
